// File: rtl/keypad_operand_loader.sv
// Collects two decimal operands from the keypad scanner, converts them to binary
// and hands them to the multiplier with a start/done handshake.
module keypad_operand_loader #(
  parameter  int DIGITS = 2,
  parameter  int OP_W   = 7,
  localparam int NDW    = $clog2(DIGITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_available,
  input  logic [3:0]      dato_i,
  input  logic            mult_done,
  output logic [OP_W-1:0] op_a,
  output logic [OP_W-1:0] op_b,
  output logic            start,
  output logic            busy,
  output logic [OP_W-1:0] entry,
  output logic [NDW-1:0]  ndigits,
  output logic            sel_b
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if ((longint'(1) << OP_W) <= pow10(DIGITS) - 1) begin : g_width_check
    $error("OP_W too small to hold DIGITS decimal digits");
  end

  typedef enum logic [1:0] {S_A, S_B, S_GO, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              da_q, da_d;
  logic              arm_q, arm_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]   entry_q, entry_d;
  logic [NDW-1:0]    ndigits_q, ndigits_d;
  logic              busy_q, busy_d;
  logic              sel_b_q, sel_b_d;
  logic              key_ev, is_digit, is_enter, is_clear;
  logic [OP_W+3:0]   acc;

  // arm_q suppresses the edge a key still held through reset would otherwise produce
  assign key_ev   = data_available & ~da_q & arm_q;
  assign is_digit = (dato_i <= 4'd9);
  assign is_enter = (dato_i == 4'hA);
  assign is_clear = (dato_i == 4'hC);
  assign acc      = {4'b0000, entry_q} * (OP_W+4)'(10) + (OP_W+4)'(dato_i);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:     if (key_ev && is_enter) state_d = S_B;
      S_B: begin
        if (key_ev && is_enter)      state_d = S_GO;
        else if (key_ev && is_clear) state_d = S_A;
      end
      S_GO:    state_d = S_WAIT;
      S_WAIT:  if (mult_done) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  always_comb begin
    da_d      = data_available;
    arm_d     = arm_q | ~data_available;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    entry_d   = entry_q;
    ndigits_d = ndigits_q;
    busy_d    = busy_q;
    if ((state_q == S_A || state_q == S_B) && key_ev) begin
      if (is_digit) begin
        if (ndigits_q < NDW'(DIGITS)) begin
          entry_d   = OP_W'(acc);
          ndigits_d = ndigits_q + NDW'(1);
        end
      end else if (is_enter) begin
        if (state_q == S_A) op_a_d = entry_q;
        else                op_b_d = entry_q;
        entry_d   = '0;
        ndigits_d = '0;
      end else if (is_clear) begin
        if (state_q == S_B) op_a_d = '0;
        entry_d   = '0;
        ndigits_d = '0;
      end
    end
    if (state_q == S_GO) busy_d = 1'b1;
    if (state_q == S_WAIT && mult_done) busy_d = 1'b0;
    sel_b_d = (state_d != S_A);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      da_q      <= 1'b0;
      arm_q     <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      entry_q   <= '0;
      ndigits_q <= '0;
      busy_q    <= 1'b0;
      sel_b_q   <= 1'b0;
    end else begin
      da_q      <= da_d;
      arm_q     <= arm_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      entry_q   <= entry_d;
      ndigits_q <= ndigits_d;
      busy_q    <= busy_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign start   = (state_q == S_GO);
  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign entry   = entry_q;
  assign ndigits = ndigits_q;
  assign busy    = busy_q;
  assign sel_b   = sel_b_q;

endmodule
